// File: rtl/exe_hazard_ctrl.sv
// EXE-stage hazard controller: registered forwarding selects, load-use bubble, branch flush.
// Optional multi-cycle mul/div hold is enabled by defining EXE_HAZARD_MULDIV_EN.
module exe_hazard_ctrl #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_valid,
  input  logic [4:0] ex_regaddr,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] mem_regaddr,
  input  logic       mem_reg_write,
  input  logic       take,
  input  logic       id_muldiv,
  output logic [1:0] for_a,
  output logic [1:0] for_b,
  output logic       stall,
  output logic       hold_id,
  output logic       is_jumped,
  output logic       ex_hold
);

  typedef enum logic [1:0] {
    RUN,
    FLUSH
`ifdef EXE_HAZARD_MULDIV_EN
    , BUSY
`endif
  } state_e;

  localparam logic [2:0] FLUSH_CNT  = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] MULDIV_CNT = 3'(MULDIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] for_a_q, for_a_d;
  logic [1:0] for_b_q, for_b_d;
  logic       in_busy;
  logic       load_use;

  // EXE result beats MEM result; r0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic en,
                                         input logic [4:0] ex_a, input logic ex_w,
                                         input logic [4:0] mem_a, input logic mem_w);
    if (en && src != 5'd0 && ex_w && src == ex_a)        return 2'b01;
    else if (en && src != 5'd0 && mem_w && src == mem_a) return 2'b10;
    else                                                 return 2'b00;
  endfunction

`ifdef EXE_HAZARD_MULDIV_EN
  assign in_busy = (state_q == BUSY);
`else
  logic unused_muldiv;
  assign in_busy       = 1'b0;
  assign unused_muldiv = ^{id_muldiv, MULDIV_CNT};
`endif

  always_comb begin
    load_use  = (state_q == RUN) && id_valid && ex_mem_read && (ex_regaddr != 5'd0) &&
                ((ex_regaddr == id_rs) || (id_uses_rt && (ex_regaddr == id_rt)));
    is_jumped = !reset && ((state_q == FLUSH) || take);
    stall     = !reset && load_use && !is_jumped;
    ex_hold   = !reset && in_busy && !take;
    hold_id   = stall || ex_hold;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for_a_d = for_a_q;
    for_b_d = for_b_q;
    if (reset) begin
      state_d = RUN;
      cnt_d   = 3'd0;
      for_a_d = 2'b00;
      for_b_d = 2'b00;
    end else begin
      case (state_q)
        FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_d = RUN;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          if (take) begin
            if (FLUSH_CYCLES > 1) begin
              state_d = FLUSH;
              cnt_d   = FLUSH_CNT;
            end else begin
              state_d = RUN;
              cnt_d   = 3'd0;
            end
`ifdef EXE_HAZARD_MULDIV_EN
          end else if (in_busy) begin
            if (cnt_q <= 3'd1) begin
              state_d = RUN;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end else if (id_muldiv && id_valid && !stall) begin
            state_d = BUSY;
            cnt_d   = MULDIV_CNT;
`endif
          end
        end
      endcase

      // A bubble or flushed slot enters EXE with no forwarding.
      if (is_jumped || stall) begin
        for_a_d = 2'b00;
        for_b_d = 2'b00;
      end else if (!hold_id && !ex_hold) begin
        for_a_d = fwd_sel(id_rs, 1'b1, ex_regaddr, ex_reg_write, mem_regaddr, mem_reg_write);
        for_b_d = fwd_sel(id_rt, id_uses_rt, ex_regaddr, ex_reg_write, mem_regaddr, mem_reg_write);
      end
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    for_a_q <= for_a_d;
    for_b_q <= for_b_d;
  end

  assign for_a = for_a_q;
  assign for_b = for_b_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl: directed test-plan cycles followed by random traffic,
// checked against a cycle-count reference model.
module tb_exe_hazard_ctrl;

  localparam int FLUSH_CYCLES  = 2;
  localparam int MULDIV_CYCLES = 4;
  localparam int RANDOM_CYCLES = 3000;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       hd;
    logic       jp;
    logic       eh;
  } exp_t;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_regaddr, mem_regaddr;
  logic       id_uses_rt, id_valid, ex_reg_write, ex_mem_read, mem_reg_write, take, id_muldiv;
  logic [1:0] for_a, for_b;
  logic       stall, hold_id, is_jumped, ex_hold;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: counts of remaining flush / busy cycles plus the expected EXE selects.
  int         flushLeft = 0;
  int         busyLeft  = 0;
  logic [1:0] modelFa   = 2'b00;
  logic [1:0] modelFb   = 2'b00;

  exe_hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MULDIV_CYCLES(MULDIV_CYCLES)) dut (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_valid(id_valid), .ex_regaddr(ex_regaddr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .mem_regaddr(mem_regaddr), .mem_reg_write(mem_reg_write),
    .take(take), .id_muldiv(id_muldiv), .for_a(for_a), .for_b(for_b), .stall(stall),
    .hold_id(hold_id), .is_jumped(is_jumped), .ex_hold(ex_hold)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [1:0] expectedSel(input logic [4:0] src, input logic used);
    if (!used || src == 5'd0)                   return 2'b00;
    if (ex_reg_write && ex_regaddr == src)      return 2'b01;
    if (mem_reg_write && mem_regaddr == src)    return 2'b10;
    return 2'b00;
  endfunction

  // Produce this cycle's expected outputs, then advance the model across the clock edge.
  task automatic modelStep();
    exp_t e;
    logic inFlush, inBusy, lu;
    e.fa = modelFa;
    e.fb = modelFb;
    if (reset) begin
      e.st = 0; e.hd = 0; e.jp = 0; e.eh = 0;
      flushLeft = 0; busyLeft = 0; modelFa = 2'b00; modelFb = 2'b00;
    end else begin
      inFlush = (flushLeft > 0);
      inBusy  = (busyLeft > 0);
      lu = !inFlush && !inBusy && id_valid && ex_mem_read && ex_regaddr != 5'd0 &&
           (ex_regaddr == id_rs || (id_uses_rt && ex_regaddr == id_rt));
      e.jp = inFlush || take;
      e.st = lu && !e.jp;
      e.eh = inBusy && !take;
      e.hd = e.st || e.eh;
      if (e.jp || e.st) begin
        modelFa = 2'b00; modelFb = 2'b00;
      end else if (!e.eh) begin
        modelFa = expectedSel(id_rs, 1'b1);
        modelFb = expectedSel(id_rt, id_uses_rt);
      end
      if (inFlush) flushLeft = flushLeft - 1;
      else if (take) begin
        flushLeft = FLUSH_CYCLES - 1;
        busyLeft  = 0;
      end else if (inBusy) busyLeft = busyLeft - 1;
`ifdef EXE_HAZARD_MULDIV_EN
      else if (id_muldiv && id_valid && !e.st) busyLeft = MULDIV_CYCLES - 1;
`endif
    end
    sbQueue.push_back(e);
  endtask

  task automatic applyStimulus(input logic rst, input logic tk, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt, input logic vld,
                               input logic [4:0] exa, input logic exw, input logic exr,
                               input logic [4:0] mema, input logic memw, input logic md);
    @(negedge clock);
    reset = rst; take = tk; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_valid = vld;
    ex_regaddr = exa; ex_reg_write = exw; ex_mem_read = exr;
    mem_regaddr = mema; mem_reg_write = memw; id_muldiv = md;
    #1;
    modelStep();
  endtask

  task automatic compareField(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField("for_a", for_a, e.fa);
    compareField("for_b", for_b, e.fb);
    compareField("stall", {1'b0, stall}, {1'b0, e.st});
    compareField("hold_id", {1'b0, hold_id}, {1'b0, e.hd});
    compareField("is_jumped", {1'b0, is_jumped}, {1'b0, e.jp});
    compareField("ex_hold", {1'b0, ex_hold}, {1'b0, e.eh});
  endtask

  // Monitor: every cycle, after the stimulus has settled, pop one expectation and compare.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (sbQueue.size() > 0) checkOutput(sbQueue.pop_front());
    end
  end

  initial begin
    reset = 1'b1; take = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_valid = 0;
    ex_regaddr = 0; ex_reg_write = 0; ex_mem_read = 0; mem_regaddr = 0; mem_reg_write = 0;
    id_muldiv = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add r3 in EXE, sub r4,r3,r3 in ID
    applyStimulus(0, 0, 3, 3, 1, 1, 3, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // EXE and MEM both write r5; rt is r0
    applyStimulus(0, 0, 5, 0, 1, 1, 5, 1, 0, 5, 1, 0);
    applyStimulus(0, 0, 5, 5, 1, 1, 5, 1, 0, 5, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw r2 then dependent use, followed by the load in MEM
    applyStimulus(0, 0, 2, 0, 0, 1, 2, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 2, 0, 0, 1, 0, 0, 0, 2, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // take, then take + load-use during the flush
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 0, 0, 1, 2, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // take together with load-use: flush wins
    applyStimulus(0, 1, 2, 0, 0, 1, 2, 1, 1, 0, 0, 0);
    // reset during the flush
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // mul/div entry, then take during its hold
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, 2, 1, 1, 1, 1, 0, 2, 1, 0);

    for (int i = 0; i < RANDOM_CYCLES; i++) begin
      applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 12,
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom), $urandom_range(0, 9) < 8,
                    5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 9) < 4,
                    5'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 9) < 1);
    end

    @(negedge clock);
    #3;
    checks++;
    if (sbQueue.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
